// File: rtl/wr_sel_decoder_pkg.sv
// Shared types and helpers for the register-file write-select decoder.
package wr_sel_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Widest decoder the helper function can build; instances slice the low DEPTH bits.
  localparam int MAX_ADDR_W = 8;
  localparam int MAX_DEPTH  = 1 << MAX_ADDR_W;

  function automatic int depth_of(input int addr_w);
    return 1 << addr_w;
  endfunction

  // Reversed one-hot: address a drives bit depth-1-a, matching the legacy decoder.
  function automatic logic [MAX_DEPTH-1:0] onehot_rev(input logic [MAX_ADDR_W-1:0] addr,
                                                      input int depth);
    logic [MAX_DEPTH-1:0] v;
    v = '0;
    for (int i = 0; i < MAX_DEPTH; i++) begin
      v[i] = (i == (depth - 1 - int'(addr)));
    end
    return v;
  endfunction

endpackage

// File: rtl/wr_sel_decoder_if.sv
// Write-request handshake: a request transfers on a cycle where req_valid && req_ready.
// The source must hold req_valid/req_addr stable until the transfer cycle.
interface wr_sel_decoder_if #(
  parameter int ADDR_W = 5
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;

  modport master (output req_valid, output req_addr, input  req_ready);
  modport slave  (input  req_valid, input  req_addr, output req_ready);
endinterface

// File: rtl/wr_sel_onehot.sv
// Combinational ADDR_W -> DEPTH reversed one-hot decoder with enable.
module wr_sel_onehot
  import wr_sel_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32
) (
  input  logic              en,
  input  logic [ADDR_W-1:0] addr,
  output logic [DEPTH-1:0]  sel
);

  logic [MAX_DEPTH-1:0] full;
  logic                 unused_full;

  always_comb begin
    full = onehot_rev(MAX_ADDR_W'(addr), DEPTH);
    sel  = en ? full[DEPTH-1:0] : '0;
  end

  assign unused_full = ^full;

endmodule

// File: rtl/wr_sel_decoder.sv
// Registered write-select decoder with self-timed register-file clear sweep.
// Optional one-hot checker on sel is enabled with macro WR_SEL_ONEHOT_CHK_EN.
module wr_sel_decoder
  import wr_sel_pkg::*;
#(
  parameter int  ADDR_W    = 5,
  parameter bit  MASK_ZERO = 1'b1,
  localparam int DEPTH     = depth_of(ADDR_W)
) (
  input  logic             clk,
  input  logic             rst_n,
  wr_sel_decoder_if.slave  req,
  input  logic             sweep_start,
  output logic [DEPTH-1:0] sel,
  output logic             sweep_active,
  output logic             sweep_done,
  output logic             masked,
  output logic             err,
  output state_t           dbg_state
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DEPTH-1:0]  sel_q, sel_d;
  logic              active_q, active_d;
  logic              done_q, done_d;
  logic              masked_q, masked_d;

  logic              accept;
  logic              zero_hit;
  logic              sweep_next;
  logic [ADDR_W-1:0] dec_addr;
  logic              dec_en;
  logic [DEPTH-1:0]  dec_sel;

  // sweep_start wins over a same-cycle request, so ready drops combinationally.
  assign req.req_ready = (state_q == IDLE) && !sweep_start;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (sweep_start) begin
          state_d = SWEEP;
          cnt_d   = '0;
        end
      end
      SWEEP: begin
        if (cnt_q == ADDR_W'(DEPTH - 1)) state_d = DONE;
        else                             cnt_d   = cnt_q + 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so sel lines up with the state it belongs to.
  always_comb begin
    accept     = req.req_valid && req.req_ready;
    zero_hit   = MASK_ZERO && (req.req_addr == '0);
    sweep_next = (state_d == SWEEP);
    dec_addr   = sweep_next ? cnt_d : req.req_addr;
    dec_en     = sweep_next || (accept && !zero_hit);
    active_d   = sweep_next;
    done_d     = (state_d == DONE);
    masked_d   = accept && zero_hit;
  end

  wr_sel_onehot #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_onehot (
    .en   (dec_en),
    .addr (dec_addr),
    .sel  (dec_sel)
  );

  assign sel_d = dec_sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      sel_q    <= '0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
      masked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      active_q <= active_d;
      done_q   <= done_d;
      masked_q <= masked_d;
    end
  end

`ifdef WR_SEL_ONEHOT_CHK_EN
  logic err_q, err_d;

  // x & (x-1) is non-zero exactly when two or more bits are set.
  always_comb begin
    err_d = err_q | ((sel_q & (sel_q - 1'b1)) != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign sel          = sel_q;
  assign sweep_active = active_q;
  assign sweep_done   = done_q;
  assign masked       = masked_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_wr_sel_decoder.sv
// Bench for wr_sel_decoder: two instances (MASK_ZERO=1 and MASK_ZERO=0) share stimulus.
module tb_wr_sel_decoder;
  import wr_sel_pkg::*;

  localparam int W = 66;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wr_sel_decoder_if #(.ADDR_W(5)) bus ();
  wr_sel_decoder_if #(.ADDR_W(5)) bus_nm ();

  assign bus_nm.req_valid = bus.req_valid;
  assign bus_nm.req_addr  = bus.req_addr;

  logic        sweep_start;
  logic [31:0] sel, sel_nm;
  logic        sa, sd, mk, er;
  logic        sa_nm, sd_nm, mk_nm, er_nm;
  state_t      st, st_nm;

  wr_sel_decoder #(.ADDR_W(5), .MASK_ZERO(1'b1)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (bus),
    .sweep_start  (sweep_start),
    .sel          (sel),
    .sweep_active (sa),
    .sweep_done   (sd),
    .masked       (mk),
    .err          (er),
    .dbg_state    (st)
  );

  wr_sel_decoder #(.ADDR_W(5), .MASK_ZERO(1'b0)) dut_nm (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (bus_nm),
    .sweep_start  (sweep_start),
    .sel          (sel_nm),
    .sweep_active (sa_nm),
    .sweep_done   (sd_nm),
    .masked       (mk_nm),
    .err          (er_nm),
    .dbg_state    (st_nm)
  );

  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic        valid;
    logic [4:0]  addr;
    logic [31:0] exp_sel;
    logic        exp_mk;
    logic [31:0] exp_sel_nm;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_sel(input logic v, input logic [4:0] a, input bit mz);
    logic [31:0] top;
    top = 32'h8000_0000;
    if (!v) return 32'h0;
    if (mz && a == 5'd0) return 32'h0;
    return top >> a;
  endfunction

  // Drive one request cycle, push its expectation, then compare after the edge.
  task automatic drive_req(input logic v, input logic [4:0] a, input logic [W-1:0] e);
    logic [W-1:0] got;
    @(negedge clk);
    bus.req_valid = v;
    bus.req_addr  = a;
    #1;
    check("ready_idle", 64'(bus.req_ready), 64'd1);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL sb_empty: got empty queue expected entry");
    end else begin
      got = exp_q.pop_front();
      check("sb_sel",       64'(sel),    64'(got[65:34]));
      check("sb_masked",    64'(mk),     64'(got[33]));
      check("sb_sel_nm",    64'(sel_nm), 64'(got[32:1]));
      check("sb_masked_nm", 64'(mk_nm),  64'(got[0]));
    end
  endtask

  task automatic full_sweep();
    logic [31:0] top;
    top = 32'h8000_0000;
    @(negedge clk);
    bus.req_valid = 1'b0;
    sweep_start   = 1'b1;
    #1;
    check("sweep_ready_comb", 64'(bus.req_ready), 64'd0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 32; i++) begin
      check("sweep_sel",    64'(sel),           64'(top >> i));
      check("sweep_active", 64'(sa),            64'd1);
      check("sweep_ready",  64'(bus.req_ready), 64'd0);
      check("sweep_nodone", 64'(sd),            64'd0);
      @(negedge clk);
      sweep_start = (i == 5);
      @(posedge clk);
      #1;
    end
    check("done_sel",    64'(sel),           64'd0);
    check("done_pulse",  64'(sd),            64'd1);
    check("done_active", 64'(sa),            64'd0);
    check("done_ready",  64'(bus.req_ready), 64'd0);
    check("done_state",  64'(st),            64'(DONE));
    @(negedge clk);
    sweep_start = 1'b0;
    @(posedge clk);
    #1;
    check("post_ready", 64'(bus.req_ready), 64'd1);
    check("post_done",  64'(sd),            64'd0);
    check("post_state", 64'(st),            64'(IDLE));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] ra;
    logic       rv;
    logic [31:0] top;
    top = 32'h8000_0000;
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    sweep_start   = 1'b0;

    vecs[0] = '{1'b1, 5'd5,  32'h0400_0000, 1'b0, 32'h0400_0000};
    vecs[1] = '{1'b0, 5'd5,  32'h0000_0000, 1'b0, 32'h0000_0000};
    vecs[2] = '{1'b1, 5'd0,  32'h0000_0000, 1'b1, 32'h8000_0000};
    vecs[3] = '{1'b0, 5'd0,  32'h0000_0000, 1'b0, 32'h0000_0000};
    vecs[4] = '{1'b1, 5'd31, 32'h0000_0001, 1'b0, 32'h0000_0001};
    vecs[5] = '{1'b1, 5'd7,  32'h0100_0000, 1'b0, 32'h0100_0000};
    vecs[6] = '{1'b1, 5'd1,  32'h4000_0000, 1'b0, 32'h4000_0000};
    vecs[7] = '{1'b1, 5'd16, 32'h0000_8000, 1'b0, 32'h0000_8000};
    vecs[8] = '{1'b0, 5'd9,  32'h0000_0000, 1'b0, 32'h0000_0000};
    vecs[9] = '{1'b1, 5'd0,  32'h0000_0000, 1'b1, 32'h8000_0000};

    // Reset state
    #12;
    check("rst_sel",    64'(sel), 64'd0);
    check("rst_active", 64'(sa),  64'd0);
    check("rst_done",   64'(sd),  64'd0);
    check("rst_masked", 64'(mk),  64'd0);
    check("rst_err",    64'(er),  64'd0);
    check("rst_state",  64'(st),  64'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;

    // Table vectors
    for (int i = 0; i < 10; i++) begin
      drive_req(vecs[i].valid, vecs[i].addr,
                {vecs[i].exp_sel, vecs[i].exp_mk, vecs[i].exp_sel_nm, 1'b0});
    end

    // Random requests against the reference model
    for (int i = 0; i < 24; i++) begin
      rv = ($urandom_range(0, 3) != 0);
      ra = 5'($urandom_range(0, 31));
      drive_req(rv, ra, {model_sel(rv, ra, 1'b1), rv && (ra == 5'd0),
                         model_sel(rv, ra, 1'b0), 1'b0});
    end

    // Full sweep, including an ignored sweep_start mid-sweep
    full_sweep();
    check("sweep_err", 64'(er), 64'd0);

    // sweep_start and a request in the same IDLE cycle
    @(negedge clk);
    sweep_start   = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_addr  = 5'd7;
    #1;
    check("prio_ready", 64'(bus.req_ready), 64'd0);
    @(posedge clk);
    #1;
    check("prio_first_sel", 64'(sel), 64'h8000_0000);
    @(negedge clk);
    sweep_start = 1'b0;
    repeat (33) @(posedge clk);
    #1;
    check("prio_back_ready", 64'(bus.req_ready), 64'd1);
    check("prio_back_sel",   64'(sel),           64'd0);
    check("prio_back_state", 64'(st),            64'(IDLE));
    @(posedge clk);
    #1;
    check("prio_accept_sel", 64'(sel), 64'h0100_0000);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(posedge clk);
    #1;
    check("prio_clear_sel", 64'(sel), 64'd0);

    // Reset in the middle of a sweep
    @(negedge clk);
    sweep_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sweep_start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("abort_pre_sel", 64'(sel), 64'(top >> 10));
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_sel",    64'(sel), 64'd0);
    check("abort_active", 64'(sa),  64'd0);
    check("abort_state",  64'(st),  64'(IDLE));
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("abort_nodone", 64'(sd), 64'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("abort_ready", 64'(bus.req_ready), 64'd1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("abort_idle_done", 64'(sd), 64'd0);
    end

    // One-hot checker under a forced illegal select
    @(negedge clk);
    force dut.sel_q = 32'h0000_0003;
    @(posedge clk);
    #1;
    release dut.sel_q;
`ifdef WR_SEL_ONEHOT_CHK_EN
    check("chk_err_set", 64'(er), 64'd1);
`else
    check("chk_err_tied", 64'(er), 64'd0);
`endif
    repeat (3) @(posedge clk);
    #1;
    check("chk_sel_recovers", 64'(sel), 64'd0);
`ifdef WR_SEL_ONEHOT_CHK_EN
    check("chk_err_sticky", 64'(er), 64'd1);
`else
    check("chk_err_still0", 64'(er), 64'd0);
`endif
    check("chk_nm_err", 64'(er_nm), 64'd0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("chk_err_rst", 64'(er), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Sweep again after reset to confirm clean recovery
    full_sweep();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wr_sel_decoder.md
Name: wr_sel_decoder

Overview:
- Parametrised, registered successor to the team's 5-to-32 register-file write-select decoder.
- Converts an ADDR_W-bit write address into a 2^ADDR_W one-hot select with valid/ready handshake, enable gating and optional zero-register masking.
- Adds a self-timed sweep mode that walks every select line once, for register-file clear after boot.
- Sits between the writeback stage and the register-file write-enable array.

Parameters:
- ADDR_W, 5, address width; DEPTH = 2^ADDR_W select lines.
- MASK_ZERO, 1, when 1, normal writes to address 0 produce no select (hardwired-zero register).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  write request present
- req_ready  output  1  block can accept request this cycle
- req_addr  input  ADDR_W  write address
- sweep_start  input  1  single-cycle pulse; begin full sweep
- sel  output  DEPTH  registered one-hot write select, reversed index mapping
- sweep_active  output  1  high while sel is driven by sweep counter (regfile muxes zero data)
- sweep_done  output  1  one-cycle pulse after last sweep select
- masked  output  1  one-cycle pulse: accepted request suppressed by MASK_ZERO
- err  output  1  sticky one-hot violation flag (see Optional Feature)

Behaviour:
- Clock and reset: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset values, applied immediately on rst_n low: sel=0, sweep_active=0, sweep_done=0, masked=0, err=0, state=IDLE, counter=0.
- Reset mid-sweep aborts with no done pulse.
- Index mapping is fixed and compatible with the existing decoder: address a asserts sel[DEPTH-1-a]. Example: addr 0 -> sel[DEPTH-1]; addr DEPTH-1 -> sel[0].
- FSM states: IDLE, SWEEP, DONE.
- req_ready is combinational: ready = (state==IDLE) && !sweep_start.
- IDLE, on accept (req_valid && req_ready):
  - Next cycle, sel = onehot(req_addr); latency 1.
  - If MASK_ZERO==1 and req_addr==0, sel stays 0 and masked pulses for 1 cycle.
- IDLE, no accept: sel=0 next cycle. sel is never held across cycles.
- IDLE, sweep_start=1: go to SWEEP and clear the counter. sweep_start has priority over a same-cycle req_valid, which is not accepted and must be held by the source.
- SWEEP:
  - Each cycle, sel = onehot(counter) and sweep_active=1.
  - counter runs 0..DEPTH-1. Address 0 is included; MASK_ZERO is ignored.
  - After counter==DEPTH-1 is issued, go to DONE.
  - sweep_start during SWEEP is ignored (no restart).
  - req_ready=0 throughout.
- DONE: sel=0, sweep_active=0, sweep_done=1 for exactly one cycle, then IDLE. req_ready=0 in DONE.
- Sweep duration: DEPTH+1 cycles from the sweep_start edge to the first cycle req_ready can be 1 again.
- Counter width is ADDR_W. It never wraps past DEPTH-1; the terminal compare is on DEPTH-1.
- At most one bit of sel is ever high.

Optional Feature:
- Macro: WR_SEL_ONEHOT_CHK_EN.
- Defined: a registered checker asserts err on the cycle after sel has more than one bit set. err is sticky until rst_n.
- Not defined: err is tied to 0 and the checker logic is absent. Timing and all other outputs are identical in both builds.

Decomposition:
- Package wr_sel_pkg:
  - state enum {IDLE, SWEEP, DONE}
  - localparam helper for DEPTH from ADDR_W
  - function onehot_rev(addr) returning the reversed one-hot vector
- Sub-module wr_sel_onehot: purely combinational ADDR_W -> DEPTH reversed decoder with enable input. Instantiated once, fed by a mux of req_addr and the sweep counter. The FSM, output registers and checker stay in the top.

Test Plan (ADDR_W=5, MASK_ZERO=1):
- Reset, then req_valid=1, req_addr=5 -> next cycle sel=32'h0400_0000 (bit 26); following cycle sel=0 with req_valid=0.
- req_addr=0 accepted -> sel=0, masked=1 for one cycle; rebuild with MASK_ZERO=0 -> sel=32'h8000_0000.
- sweep_start pulse ->
  - 32 consecutive cycles with sel bits 31 down to 0, one each, and sweep_active=1
  - then sweep_done=1 for one cycle
  - req_ready=0 for 33 cycles total
- sweep_start and req_valid (addr 7) in the same IDLE cycle -> req_ready=0, sweep runs, request accepted first cycle back in IDLE, sel bit 24 one cycle later.
- rst_n low while counter=10 in SWEEP -> sel=0, sweep_active=0 immediately; no sweep_done; after release req_ready=1.
- With WR_SEL_ONEHOT_CHK_EN: force sel to 32'h0000_0003 -> err=1 next cycle and stays 1 until reset. Without the macro, err stays 0 under the same force.
